register_unit: RTL and testbench
================================

# register_unit

RV32I register unit for the single-cycle core: 32 × 32-bit general-purpose registers, two combinational read ports feeding the ALU operand muxes, and one synchronous write port. It consumes the writeback word produced by the RU write-data source mux (ALU result, load data or PC+4). x0 is hardwired to zero, and x2 (sp) has a configurable reset value.

## Interface
Parameters:
- `XLEN`, 32, register/data width.
- `SP_INIT`, 32'h0000_0FFC, reset value of x2.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rs1`  in  5  read port 1 address.
- `rs2`  in  5  read port 2 address.
- `rd`  in  5  write address.
- `RUWr`  in  1  write enable.
- `RUDataWr`  in  XLEN  write data from the writeback mux.
- `RURs1`  out  XLEN  read data, port 1.
- `RURs2`  out  XLEN  read data, port 2.

## Operation
- Storage: registers x1..x31 are flops. x0 is not stored; reads of x0 always return 0.
- Read: `RURs1 = reg[rs1]` and `RURs2 = reg[rs2]`, combinational. Both ports are independent, and `rs1 == rs2` is legal.
- Write: at a rising edge with `RUWr=1`, `rst=0` and `rd != 0`, `reg[rd] <= RUDataWr`, the full 32 bits with no extension or masking.
- Write to x0: dropped silently and has no side effect.
- Reset: at a rising edge with `rst=1`, x1 and x3..x31 are set to 0 and x2 is set to `SP_INIT`.
  - Reset has priority over a simultaneous write; the write is lost.
- Reset mid-operation: any in-flight write in the reset cycle is discarded. Writes resume on the first edge with `rst=0`.
- Read-during-write, same address, without bypass: the read returns the old value until the edge, then the new value.

## Timing
- Read latency 0: outputs follow `rs1`/`rs2` and register contents combinationally within the cycle.
- Write latency 1: a value written at edge N is visible on the read ports immediately after edge N.
- Output values after reset:
  - `RURs1`/`RURs2` read 0 for every address except x2, which reads `SP_INIT`.
  - x0 reads 0 always.
- There is no handshake. Exactly one write per cycle is possible.

## Configuration
- Macro `RU_WRITE_BYPASS_EN`.
- Defined:
  - When `RUWr=1`, `rst=0`, `rd != 0` and `rd == rsN`, the port `RURsN` returns `RUDataWr` in the same cycle, before the edge.
  - Each port is bypassed independently, and both ports are bypassed when `rs1 == rs2 == rd`.
  - No bypass when `rd == 0` or while `rst=1`.
- Undefined: pure register read, as described under Operation. This is required for the single-cycle core, where `RUDataWr` depends combinationally on `RURs1`/`RURs2`: enabling bypass there creates a combinational loop.
- The flopped state is identical in both builds.

## Structure
- Shared package `riscv_pkg` holds:
  - `XLEN`
  - `REG_ADDR_W = 5`
  - `NUM_REGS = 32`
  - `typedef logic [XLEN-1:0] word_t`
  - `typedef logic [REG_ADDR_W-1:0] reg_addr_t`
  - named constants `REG_ZERO = 5'd0` and `REG_SP = 5'd2`
- One sub-module, `ru_read_port`. It contains:
  - the 32:1 read mux
  - the x0 zero-forcing
  - the optional bypass compare
- `ru_read_port` is instantiated twice, for `RURs1` and `RURs2`. The write/reset logic stays in the top.

## Test plan
- Hold `rst=1` for 2 cycles, then sweep `rs1`/`rs2` over 0..31. Required: every register reads 0 except x2, which reads 32'h0000_0FFC.
- Write x5 = 32'hDEAD_BEEF (`RUWr=1`, `rd=5`), then read with `rs1=5`, `rs2=5`. Required: both ports read 32'hDEAD_BEEF on the cycle after the edge; without bypass, the old value 0 is seen during the write cycle.
- Write x0 = 32'hFFFF_FFFF. Required: `RURs1` at `rs1=0` reads 0 and no other register changes.
- Assert `rst=1` and, in the same cycle, write x7 = 32'h1234_5678. Required: x7 reads 0 afterwards and x2 reads `SP_INIT`.
- Write x31 = 32'h8000_0001 with `RUWr=0`. Required: x31 is unchanged at 0. Then write all of x1..x31 with distinct values i×32'h0101_0101. Required: each register reads back its own value, with no aliasing.
- With `RU_WRITE_BYPASS_EN` defined, set `rd=rs1=9`, `RUWr=1`, `RUDataWr=32'hCAFE_0009`, with `rs2=10` holding 32'h0000_000A. Required: in the same cycle `RURs1=32'hCAFE_0009` and `RURs2=32'h0000_000A`.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: widths, register-file geometry and the
// architectural register names the register unit cares about.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [XLEN-1:0]       word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
  localparam reg_addr_t REG_SP   = 5'd2;

  // Default stack-pointer value loaded into x2 at reset.
  localparam word_t SP_INIT_DEFAULT = 32'h0000_0FFC;

endpackage

// File: rtl/register_unit_if.sv
// Register unit port bundle: two read ports and one write port.
// There is no handshake: rs1/rs2 select read data combinationally on
// RURs1/RURs2 every cycle, and one write per cycle is taken at the rising
// clock edge whenever RUWr is high (writes to x0 are ignored).
interface register_unit_if #(
  parameter int XLEN = riscv_pkg::XLEN
);
  import riscv_pkg::*;

  reg_addr_t       rs1;
  reg_addr_t       rs2;
  reg_addr_t       rd;
  logic            RUWr;
  logic [XLEN-1:0] RUDataWr;
  logic [XLEN-1:0] RURs1;
  logic [XLEN-1:0] RURs2;

  // Core side: issues addresses and writeback data, consumes operands.
  modport master (
    output rs1, rs2, rd, RUWr, RUDataWr,
    input  RURs1, RURs2
  );

  // Register unit side.
  modport slave (
    input  rs1, rs2, rd, RUWr, RUDataWr,
    output RURs1, RURs2
  );

endinterface

// File: rtl/register_unit_read_port.sv
// ru_read_port: one combinational read port of the register unit.
// Selects a register from the flattened file, forces x0 to zero and,
// when RU_WRITE_BYPASS_EN is defined, forwards the pending write data to
// the port when the write targets the address being read.
module ru_read_port
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic [NUM_REGS-1:0][XLEN-1:0] regs,
  input  reg_addr_t                     rs,
`ifdef RU_WRITE_BYPASS_EN
  input  reg_addr_t                     rd,
  input  logic                          wr_en,
  input  logic                          rst,
  input  logic [XLEN-1:0]               wr_data,
`endif
  output logic [XLEN-1:0]               rdata
);

  // Read mux, x0 forcing and optional same-cycle write forwarding.
  always_comb begin
    rdata = regs[rs];
    if (rs == REG_ZERO) begin
      rdata = '0;
    end
`ifdef RU_WRITE_BYPASS_EN
    // Forward only a write that will actually commit at the next edge.
    if (wr_en && !rst && (rd != REG_ZERO) && (rd == rs)) begin
      rdata = wr_data;
    end
`endif
  end

endmodule

// File: rtl/register_unit.sv
// register_unit: RV32I general-purpose register file, x1..x31 in flops,
// x0 hardwired to zero, x2 reset to SP_INIT. Two combinational read ports,
// one synchronous write port.
// Optional feature macro: RU_WRITE_BYPASS_EN (write-to-read forwarding);
// leave it undefined for the single-cycle core, where the writeback data
// depends combinationally on the read ports.
module register_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN    = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] SP_INIT = SP_INIT_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  register_unit_if.slave ru
);

  logic [XLEN-1:0]               regs_q [1:NUM_REGS-1];
  logic [XLEN-1:0]               regs_d [1:NUM_REGS-1];
  logic [NUM_REGS-1:0][XLEN-1:0] regs_flat;

  // Next-state: apply at most one write; writes to x0 are dropped.
  always_comb begin
    for (int i = 1; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (ru.RUWr && (ru.rd != REG_ZERO)) begin
      regs_d[ru.rd] = ru.RUDataWr;
    end
  end

  // Register state; reset wins over a write in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= (i == int'(REG_SP)) ? SP_INIT : '0;
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Flatten the file for the read muxes; slot 0 is a constant zero.
  always_comb begin
    regs_flat[0] = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      regs_flat[i] = regs_q[i];
    end
  end

  ru_read_port #(.XLEN(XLEN)) u_port1 (
    .regs    (regs_flat),
    .rs      (ru.rs1),
`ifdef RU_WRITE_BYPASS_EN
    .rd      (ru.rd),
    .wr_en   (ru.RUWr),
    .rst     (rst),
    .wr_data (ru.RUDataWr),
`endif
    .rdata   (ru.RURs1)
  );

  ru_read_port #(.XLEN(XLEN)) u_port2 (
    .regs    (regs_flat),
    .rs      (ru.rs2),
`ifdef RU_WRITE_BYPASS_EN
    .rd      (ru.rd),
    .wr_en   (ru.RUWr),
    .rst     (rst),
    .wr_data (ru.RUDataWr),
`endif
    .rdata   (ru.RURs2)
  );

endmodule

// File: tb/tb_register_unit.sv
// Bench for register_unit: directed vectors, expected read data queued by
// the driver, compared by a negedge monitor.
module tb_register_unit;

  logic clk;
  logic rst;

  register_unit_if #(.XLEN(32)) ru_if ();

  register_unit dut (
    .clk (clk),
    .rst (rst),
    .ru  (ru_if.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] SP = 32'h0000_0FFC;
  localparam logic [31:0] K  = 32'h0101_0101;

  // Scoreboard: {exp RURs1, exp RURs2} per checked cycle.
  logic [63:0] exp_q[$];
  string       tag_q[$];
  int          pass_cnt  = 0;
  int          total_cnt = 0;

  // Monitor: inputs change at posedge+1, outputs are sampled at negedge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [63:0] e;
      string       t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      total_cnt++;
      if (ru_if.RURs1 === e[63:32]) pass_cnt++;
      else $display("FAIL %s port1: got %h expected %h", t, ru_if.RURs1, e[63:32]);
      total_cnt++;
      if (ru_if.RURs2 === e[31:0]) pass_cnt++;
      else $display("FAIL %s port2: got %h expected %h", t, ru_if.RURs2, e[31:0]);
    end
  end

  // Driver: one cycle of stimulus, optionally with an expected read pair.
  task automatic drive(input logic r, input logic w, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] a1,
                       input logic [4:0] a2, input logic chk,
                       input logic [31:0] e1, input logic [31:0] e2,
                       input string tag);
    @(posedge clk);
    #1;
    rst            = r;
    ru_if.RUWr     = w;
    ru_if.rd       = wa;
    ru_if.RUDataWr = wd;
    ru_if.rs1      = a1;
    ru_if.rs2      = a2;
    if (chk) begin
      exp_q.push_back({e1, e2});
      tag_q.push_back(tag);
    end
  endtask

  initial begin
    logic [31:0] v1, v2;
    rst            = 1'b1;
    ru_if.RUWr     = 1'b0;
    ru_if.rd       = '0;
    ru_if.RUDataWr = '0;
    ru_if.rs1      = '0;
    ru_if.rs2      = '0;

    // Reset held for two edges
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, "rst");
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, "rst");

    // Post-reset sweep: all zero except x2
    for (int i = 0; i < 32; i++) begin
      v1 = (i == 2) ? SP : 32'h0;
      v2 = ((31 - i) == 2) ? SP : 32'h0;
      drive(0, 0, 0, 0, 5'(i), 5'(31 - i), 1, v1, v2, "reset_sweep");
    end

    // Write x5 and read in the write cycle and after
`ifdef RU_WRITE_BYPASS_EN
    drive(0, 1, 5, 32'hDEAD_BEEF, 5, 5, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "x5_wr_cycle");
`else
    drive(0, 1, 5, 32'hDEAD_BEEF, 5, 5, 1, 32'h0, 32'h0, "x5_wr_cycle");
`endif
    drive(0, 0, 0, 0, 5, 5, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "x5_after");

    // Write to x0 is dropped (and never forwarded)
    drive(0, 1, 0, 32'hFFFF_FFFF, 0, 5, 1, 32'h0, 32'hDEAD_BEEF, "x0_wr_cycle");
    drive(0, 0, 0, 0, 0, 5, 1, 32'h0, 32'hDEAD_BEEF, "x0_after");
    drive(0, 0, 0, 0, 2, 1, 1, SP, 32'h0, "x0_no_side_effect");

    // Populate x7 and x2, then reset with a simultaneous write to x7
`ifdef RU_WRITE_BYPASS_EN
    drive(0, 1, 7, 32'h0000_0777, 7, 2, 1, 32'h0000_0777, SP, "x7_wr");
    drive(0, 1, 2, 32'h1111_2222, 2, 7, 1, 32'h1111_2222, 32'h0000_0777, "x2_wr");
`else
    drive(0, 1, 7, 32'h0000_0777, 7, 2, 1, 32'h0, SP, "x7_wr");
    drive(0, 1, 2, 32'h1111_2222, 2, 7, 1, SP, 32'h0000_0777, "x2_wr");
`endif
    drive(1, 1, 7, 32'h1234_5678, 7, 2, 1, 32'h0000_0777, 32'h1111_2222, "rst_wr_cycle");
    drive(0, 0, 0, 0, 7, 2, 1, 32'h0, SP, "rst_wr_after");
    drive(0, 0, 0, 0, 5, 5, 1, 32'h0, 32'h0, "rst_clears_x5");

    // RUWr=0 keeps x31 unchanged
    drive(0, 0, 31, 32'h8000_0001, 31, 31, 1, 32'h0, 32'h0, "x31_nowr_cycle");
    drive(0, 0, 0, 0, 31, 31, 1, 32'h0, 32'h0, "x31_nowr_after");

    // Fill x1..x31 with i*K; port2 reads the previously written register
    for (int i = 1; i < 32; i++) begin
`ifdef RU_WRITE_BYPASS_EN
      v1 = K * i;
`else
      v1 = (i == 2) ? SP : 32'h0;
`endif
      v2 = K * (i - 1);
      drive(0, 1, 5'(i), K * i, 5'(i), 5'(i - 1), 1, v1, v2, "fill");
    end

    // Read back every register on both ports
    for (int i = 1; i < 32; i++) begin
      drive(0, 0, 0, 0, 5'(i), 5'(32 - i), 1, K * i, K * (32 - i), "readback");
    end

    // Bypass scenario: x10 = 0xA, then write x9 while reading x9 / x10
    drive(0, 1, 10, 32'h0000_000A, 10, 10, 0, 0, 0, "x10_wr");
`ifdef RU_WRITE_BYPASS_EN
    drive(0, 1, 9, 32'hCAFE_0009, 9, 10, 1, 32'hCAFE_0009, 32'h0000_000A, "bypass_x9");
`else
    drive(0, 1, 9, 32'hCAFE_0009, 9, 10, 1, 32'h0909_0909, 32'h0000_000A, "nobypass_x9");
`endif
    drive(0, 0, 0, 0, 9, 10, 1, 32'hCAFE_0009, 32'h0000_000A, "x9_after");

    // Drain the scoreboard with a bounded wait
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) @(posedge clk);
    if (exp_q.size() != 0) begin
      total_cnt++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
